// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode field, fetch FSM states
// and the fetch/decode pipeline payload.
package cpu_pkg;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned INSTR_W = 16;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned OP_LSB  = INSTR_W - OP_W;

   localparam logic [OP_W-1:0]    HALT_OP = 4'hF;
   localparam logic [INSTR_W-1:0] NOP     = '0;

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
      logic               valid;
   } fd_t;

   localparam fd_t FD_RST = '{pc: '0, instr: NOP, valid: 1'b0};

   function automatic logic [OP_W-1:0] opcode(input logic [INSTR_W-1:0] instr);
      return instr[OP_LSB +: OP_W];
   endfunction

endpackage

// File: rtl/pipe_reg.sv
// Width-parameterised enable register with an asynchronous reset value;
// used for the PC and for the fetch/decode pipeline register.
module pipe_reg #(
   parameter int unsigned    W       = 8,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and loads the fetch/decode register; handles stall, branch redirect and HALT.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] PC_INC   = ADDR_W'(1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [INSTR_W-1:0] if_instr,
   output logic               if_valid,
   output logic               halted
);

   fetch_state_e      state, state_nx;
   logic [ADDR_W-1:0] pc, pc_d;
   logic              pc_en;
   fd_t               fd_q, fd_d;
   logic              fd_en;

   pipe_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc)
   );

   pipe_reg #(.W($bits(fd_t)), .RST_VAL(FD_RST)) u_fd (
      .clk (clk),
      .rst (rst),
      .en  (fd_en),
      .d   (fd_d),
      .q   (fd_q)
   );

   // halted is registered alongside the state so it tracks HALT exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= BOOT;
         halted <= 1'b0;
      end else begin
         state  <= state_nx;
         halted <= (state_nx == HALT);
      end
   end

   // Next-state, next-PC and pipeline-register load selection
   always_comb begin
      state_nx = state;
      pc_en    = 1'b0;
      pc_d     = pc;
      fd_en    = 1'b0;
      fd_d     = fd_q;

      unique case (state)
         BOOT: begin
            state_nx = RUN;
         end

         RUN: begin
            if (br_taken) begin
               pc_en = 1'b1;
               pc_d  = br_target;
               fd_en = 1'b1;
               fd_d  = '{pc: fd_q.pc, instr: NOP, valid: 1'b0};
            end else if (!stall) begin
               fd_en = 1'b1;
               fd_d  = '{pc: pc, instr: imem_rdata, valid: 1'b1};
               if (opcode(imem_rdata) == HALT_OP) begin
                  state_nx = HALT;
               end else begin
                  pc_en = 1'b1;
                  pc_d  = pc + PC_INC;
               end
            end
         end

         HALT: begin
            // an older branch still in execute squashes the HALT
            if (br_taken) begin
               state_nx = RUN;
               pc_en    = 1'b1;
               pc_d     = br_target;
               fd_en    = 1'b1;
               fd_d     = '{pc: fd_q.pc, instr: NOP, valid: 1'b0};
            end else if (!stall) begin
               fd_en = 1'b1;
               fd_d  = '{pc: fd_q.pc, instr: NOP, valid: 1'b0};
            end
         end

         default: begin
            state_nx = BOOT;
         end
      endcase
   end

   assign imem_addr = pc;
   assign if_pc     = fd_q.pc;
   assign if_instr  = fd_q.instr;
   assign if_valid  = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural fetch model checked every cycle, plus
// hand-computed expectations along the directed scenario.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        br_taken;
   logic [7:0]  br_target;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [7:0]  if_pc;
   logic [15:0] if_instr;
   logic        if_valid;
   logic        halted;

   logic [15:0] rom [256];

   int n_tests = 0;
   int n_fail  = 0;

   // model of what the stage must present
   logic [7:0]  m_pc;
   logic [7:0]  m_ipc;
   logic [15:0] m_instr;
   logic        m_valid;
   logic        m_halted;
   logic        m_boot;

   always #5 clk = ~clk;

   assign imem_rdata = rom[imem_addr];

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .if_pc      (if_pc),
      .if_instr   (if_instr),
      .if_valid   (if_valid),
      .halted     (halted)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = 8'h00;
      m_ipc    = 8'h00;
      m_instr  = 16'h0000;
      m_valid  = 1'b0;
      m_halted = 1'b0;
      m_boot   = 1'b1;
   endtask

   // advance one clock; the model's next values come from the inputs held across the edge
   task automatic step();
      logic [7:0]  npc;
      logic [7:0]  nipc;
      logic [15:0] ni;
      logic        nv, nh, nb;
      npc = m_pc; nipc = m_ipc; ni = m_instr; nv = m_valid; nh = m_halted; nb = m_boot;
      if (rst) begin
         npc = 8'h00; nipc = 8'h00; ni = 16'h0000; nv = 1'b0; nh = 1'b0; nb = 1'b1;
      end else if (m_boot) begin
         nb = 1'b0;
      end else if (br_taken) begin
         npc = br_target; ni = 16'h0000; nv = 1'b0; nh = 1'b0;
      end else if (stall) begin
         // everything holds
      end else if (m_halted) begin
         ni = 16'h0000; nv = 1'b0;
      end else begin
         nipc = m_pc;
         ni   = rom[m_pc];
         nv   = 1'b1;
         if (rom[m_pc][15:12] == 4'hF) nh = 1'b1;
         else npc = m_pc + 8'd1;
      end
      @(posedge clk);
      #1;
      m_pc = npc; m_ipc = nipc; m_instr = ni; m_valid = nv; m_halted = nh; m_boot = nb;
   endtask

   always @(negedge clk) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("if_pc",     32'(if_pc),     32'(m_ipc));
      chk("if_instr",  32'(if_instr),  32'(m_instr));
      chk("if_valid",  32'(if_valid),  32'(m_valid));
      chk("halted",    32'(halted),    32'(m_halted));
   end

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 16'h0100 + 16'(i);
      rom[0] = 16'h1234;
      rom[6] = 16'hF000;

      rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
      model_reset();

      // reset and boot bubble
      repeat (5) step();
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_addr",  32'(imem_addr), 32'd0);
      rst = 1'b0;
      step();
      chk("boot_valid", 32'(if_valid), 32'd0);
      chk("boot_addr",  32'(imem_addr), 32'd0);
      step();
      chk("first_instr", 32'(if_instr), 32'h1234);
      chk("first_pc",    32'(if_pc), 32'd0);
      chk("first_valid", 32'(if_valid), 32'd1);
      chk("first_addr",  32'(imem_addr), 32'd1);

      // stall at pc=3
      step(); step();
      stall = 1'b1;
      repeat (3) step();
      chk("stall_pc",    32'(if_pc), 32'd2);
      chk("stall_instr", 32'(if_instr), 32'h0102);
      chk("stall_addr",  32'(imem_addr), 32'd3);
      stall = 1'b0;
      step();
      chk("unstall_pc", 32'(if_pc), 32'd3);

      // branch together with stall at pc=5
      step();
      chk("pre_br_addr", 32'(imem_addr), 32'd5);
      br_taken = 1'b1; br_target = 8'h40; stall = 1'b1;
      step();
      chk("br_addr",  32'(imem_addr), 32'h40);
      chk("br_valid", 32'(if_valid), 32'd0);
      chk("br_instr", 32'(if_instr), 32'd0);
      br_taken = 1'b0; stall = 1'b0;
      step();
      chk("br_fetch_instr", 32'(if_instr), 32'h0140);
      chk("br_fetch_pc",    32'(if_pc), 32'h40);

      // wrap through 0xFF
      br_taken = 1'b1; br_target = 8'hFE;
      step();
      br_taken = 1'b0;
      step();
      chk("wrap_pc_fe", 32'(if_pc), 32'hFE);
      step();
      chk("wrap_pc_ff", 32'(if_pc), 32'hFF);
      chk("wrap_v_ff",  32'(if_valid), 32'd1);
      step();
      chk("wrap_pc_00", 32'(if_pc), 32'h00);
      chk("wrap_v_00",  32'(if_valid), 32'd1);
      chk("wrap_i_00",  32'(if_instr), 32'h1234);

      // run into HALT at address 6
      repeat (6) step();
      chk("halt_instr",  32'(if_instr), 32'hF000);
      chk("halt_valid",  32'(if_valid), 32'd1);
      chk("halt_flag",   32'(halted), 32'd1);
      chk("halt_addr",   32'(imem_addr), 32'd6);
      repeat (10) step();
      chk("halted_valid", 32'(if_valid), 32'd0);
      chk("halted_flag",  32'(halted), 32'd1);
      chk("halted_addr",  32'(imem_addr), 32'd6);
      br_taken = 1'b1; br_target = 8'h10;
      step();
      br_taken = 1'b0;
      chk("resume_flag", 32'(halted), 32'd0);
      chk("resume_addr", 32'(imem_addr), 32'h10);
      step();
      chk("resume_pc",    32'(if_pc), 32'h10);
      chk("resume_instr", 32'(if_instr), 32'h0110);

      // async reset between edges at pc=0x22
      repeat (17) step();
      chk("pre_rst_addr", 32'(imem_addr), 32'h22);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_addr",  32'(imem_addr), 32'd0);
      chk("arst_valid", 32'(if_valid), 32'd0);
      chk("arst_instr", 32'(if_instr), 32'd0);
      chk("arst_pc",    32'(if_pc), 32'd0);
      chk("arst_halt",  32'(halted), 32'd0);
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;
      step();
      chk("reboot_valid", 32'(if_valid), 32'd0);
      step();
      chk("reboot_instr", 32'(if_instr), 32'h1234);
      chk("reboot_valid2", 32'(if_valid), 32'd1);
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
